dcache_store_port: RTL and testbench

// - D$ responder for the store-buffer write request port: accepts one committed store per handshake and answers data_gnt.
// - Write-through, no-write-allocate: a tag hit updates the data SRAM with byte enables; every store is queued to memory.
// - Sits between store_buffer.req_port_o and the D$ tag/data SRAMs plus the memory write channel.

---
 rtl/dcache_store_port_pkg.sv | 46 ++++
 rtl/dcache_wq_fifo.sv | 56 +++++
 rtl/dcache_store_port.sv | 145 ++++++++++++++
 tb/tb_dcache_store_port.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_store_port_pkg.sv
// Shared types and sizes for the D$ store port.
// Request/response bundles, write-queue entry and FSM states.
package dcache_store_port_pkg;

  localparam int XLEN                = 64;
  localparam int NR_WAYS             = 4;
  localparam int WQ_DEPTH            = 4;
  localparam int PADDR_WIDTH         = 56;
  localparam int DCACHE_INDEX_WIDTH  = 12;
  localparam int DCACHE_OFFSET_WIDTH = 4;
  localparam int DCACHE_TAG_WIDTH    = PADDR_WIDTH - DCACHE_INDEX_WIDTH;
  localparam int TAG_ENTRY_W         = DCACHE_TAG_WIDTH + 1;
  localparam int SET_W   = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
  localparam int WADDR_W = DCACHE_INDEX_WIDTH - 3;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic [XLEN/8-1:0]             data_be;
    logic [1:0]                    data_size;
    logic                          data_req;
    logic                          data_we;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic            data_gnt;
    logic            data_rvalid;
    logic [XLEN-1:0] data_rdata;
  } dcache_req_o_t;

  typedef struct packed {
    logic [PADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0]        data;
    logic [XLEN/8-1:0]      be;
    logic [1:0]             size;
  } dcache_wq_entry_t;

  typedef enum logic {
    IDLE,
    LOOKUP
  } store_port_state_e;

endpackage

// File: rtl/dcache_wq_fifo.sv
// Memory write queue: circular FIFO of pending stores.
// Head entry is presented continuously while not empty.
module dcache_wq_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  entry_t                 data_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Entry storage needs no reset; pointers decide validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dcache_store_port.sv
// Write-through, no-write-allocate D$ store port.
// Tag lookup, byte-enabled hit write, queued memory write.
module dcache_store_port
  import dcache_store_port_pkg::*;
#(
  parameter int NR_WAYS  = dcache_store_port_pkg::NR_WAYS,
  parameter int WQ_DEPTH = dcache_store_port_pkg::WQ_DEPTH
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  dcache_req_i_t                    req_port_i,
  output dcache_req_o_t                    req_port_o,
  input  logic                             arb_gnt_i,
  output logic                             tag_req_o,
  output logic [SET_W-1:0]                 tag_addr_o,
  input  logic [NR_WAYS*TAG_ENTRY_W-1:0]   tag_rdata_i,
  output logic                             data_we_o,
  output logic [NR_WAYS-1:0]               data_way_o,
  output logic [WADDR_W-1:0]               data_addr_o,
  output logic [XLEN-1:0]                  data_wdata_o,
  output logic [XLEN/8-1:0]                data_be_o,
  output logic                             mem_valid_o,
  input  logic                             mem_ready_i,
  output logic [PADDR_WIDTH-1:0]           mem_addr_o,
  output logic [XLEN-1:0]                  mem_data_o,
  output logic [XLEN/8-1:0]                mem_be_o,
  output logic [1:0]                       mem_size_o,
  output logic                             wq_empty_o
);

  store_port_state_e             state_q;
  logic [DCACHE_TAG_WIDTH-1:0]   tag_q;
  logic [DCACHE_INDEX_WIDTH-1:0] idx_q;
  logic [XLEN-1:0]               wdata_q;
  logic [XLEN/8-1:0]             be_q;
  logic [1:0]                    size_q;

  logic                          accept;
  logic                          lookup;
  logic [NR_WAYS-1:0]            hit_way;
  logic [NR_WAYS-1:0]            hit_sel;
  logic                          wq_full;
  logic                          wq_empty;
  logic                          wq_pop;
  logic                          wq_room;
  dcache_wq_entry_t              wq_in;
  dcache_wq_entry_t              wq_head;
  logic [$clog2(WQ_DEPTH):0]     unused_wq_cnt;
  logic                          unused_req;

  assign unused_req = ^{req_port_i.kill_req, req_port_i.tag_valid};

  assign lookup  = (state_q == LOOKUP);
  assign wq_pop  = mem_valid_o & mem_ready_i;
  assign wq_room = ~wq_full | wq_pop;
  assign accept  = (state_q == IDLE) & req_port_i.data_req &
                   req_port_i.data_we & arb_gnt_i & wq_room;

  // Only the grant is meaningful on the response bundle.
  always_comb begin
    req_port_o          = '0;
    req_port_o.data_gnt = accept;
  end

  assign tag_req_o  = accept;
  assign tag_addr_o =
    req_port_i.address_index[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];

  // Per-way tag compare against the latched store tag.
  always_comb begin
    hit_way = '0;
    for (int i = 0; i < NR_WAYS; i++) begin
      hit_way[i] = tag_rdata_i[i*TAG_ENTRY_W + DCACHE_TAG_WIDTH] &
        (tag_rdata_i[i*TAG_ENTRY_W +: DCACHE_TAG_WIDTH] == tag_q);
    end
  end

  // Isolate lowest set bit so a multi-hit still writes one way.
  assign hit_sel = hit_way & (~hit_way + 1'b1);

  assign data_we_o    = lookup & (|hit_way);
  assign data_way_o   = lookup ? hit_sel : '0;
  assign data_addr_o  = idx_q[DCACHE_INDEX_WIDTH-1:3];
  assign data_wdata_o = wdata_q;
  assign data_be_o    = be_q;

  assign wq_in = '{addr: {tag_q, idx_q}, data: wdata_q,
                   be: be_q, size: size_q};

  dcache_wq_fifo #(
    .DEPTH   (WQ_DEPTH),
    .entry_t (dcache_wq_entry_t)
  ) i_wq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (lookup),
    .data_i  (wq_in),
    .pop_i   (wq_pop),
    .head_o  (wq_head),
    .full_o  (wq_full),
    .empty_o (wq_empty),
    .count_o (unused_wq_cnt)
  );

  assign mem_valid_o = ~wq_empty;
  assign mem_addr_o  = wq_head.addr;
  assign mem_data_o  = wq_head.data;
  assign mem_be_o    = wq_head.be;
  assign mem_size_o  = wq_head.size;
  assign wq_empty_o  = wq_empty & (state_q == IDLE);

  // Two-state handshake FSM and request latch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= LOOKUP;
            tag_q   <= req_port_i.address_tag;
            idx_q   <= req_port_i.address_index;
            wdata_q <= req_port_i.data_wdata;
            be_q    <= req_port_i.data_be;
            size_q  <= req_port_i.data_size;
          end
        end
        LOOKUP:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // More than one matching way means the tag array is corrupt.
  a_onehot_hit: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    lookup |-> $onehot0(hit_way)
  );

endmodule

// File: tb/tb_dcache_store_port.sv
// Directed bench for the D$ store port.
// Hand-computed expectations plus an in-order memory write log.
module tb_dcache_store_port;
  import dcache_store_port_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  dcache_req_i_t req;
  dcache_req_o_t rsp;
  logic arb_gnt_i;
  logic tag_req_o;
  logic [SET_W-1:0] tag_addr_o;
  logic [NR_WAYS*TAG_ENTRY_W-1:0] tag_rdata_i;
  logic data_we_o;
  logic [NR_WAYS-1:0] data_way_o;
  logic [WADDR_W-1:0] data_addr_o;
  logic [XLEN-1:0] data_wdata_o;
  logic [XLEN/8-1:0] data_be_o;
  logic mem_valid_o;
  logic mem_ready_i;
  logic [PADDR_WIDTH-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_data_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [1:0] mem_size_o;
  logic wq_empty_o;

  int passed = 0;
  int total = 0;
  dcache_wq_entry_t got_q[$];
  dcache_wq_entry_t exp_q[$];

  dcache_store_port dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_port_i   (req),
    .req_port_o   (rsp),
    .arb_gnt_i    (arb_gnt_i),
    .tag_req_o    (tag_req_o),
    .tag_addr_o   (tag_addr_o),
    .tag_rdata_i  (tag_rdata_i),
    .data_we_o    (data_we_o),
    .data_way_o   (data_way_o),
    .data_addr_o  (data_addr_o),
    .data_wdata_o (data_wdata_o),
    .data_be_o    (data_be_o),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_be_o     (mem_be_o),
    .mem_size_o   (mem_size_o),
    .wq_empty_o   (wq_empty_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (rst_ni && mem_valid_o && mem_ready_i)
      got_q.push_back('{addr: mem_addr_o, data: mem_data_o,
                        be: mem_be_o, size: mem_size_o});
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic dcache_req_i_t mk(
    input logic [DCACHE_INDEX_WIDTH-1:0] idx,
    input logic [DCACHE_TAG_WIDTH-1:0] tag,
    input logic [XLEN-1:0] d, input logic [7:0] be,
    input logic [1:0] sz);
    dcache_req_i_t r;
    r = '0;
    r.address_index = idx;
    r.address_tag = tag;
    r.data_wdata = d;
    r.data_be = be;
    r.data_size = sz;
    r.data_req = 1'b1;
    r.data_we = 1'b1;
    return r;
  endfunction

  function automatic dcache_wq_entry_t ent(input dcache_req_i_t r);
    return '{addr: {r.address_tag, r.address_index},
             data: r.data_wdata, be: r.data_be, size: r.data_size};
  endfunction

  function automatic logic [NR_WAYS*TAG_ENTRY_W-1:0] tags(
    input int w, input logic [DCACHE_TAG_WIDTH-1:0] t);
    logic [NR_WAYS*TAG_ENTRY_W-1:0] v;
    for (int i = 0; i < NR_WAYS; i++) begin
      if (i == w) v[i*TAG_ENTRY_W +: TAG_ENTRY_W] = {1'b1, t};
      else v[i*TAG_ENTRY_W +: TAG_ENTRY_W] =
        {1'b1, t ^ DCACHE_TAG_WIDTH'(i + 1)};
    end
    if (w < 0) v[TAG_ENTRY_W-1:0] = {1'b0, t};
    return v;
  endfunction

  task automatic reset_chk(input string p);
    chk({p, "_gnt"}, 64'(rsp.data_gnt), 64'(0));
    chk({p, "_rvalid"}, 64'(rsp.data_rvalid), 64'(0));
    chk({p, "_rdata"}, rsp.data_rdata, 64'(0));
    chk({p, "_tag_req"}, 64'(tag_req_o), 64'(0));
    chk({p, "_data_we"}, 64'(data_we_o), 64'(0));
    chk({p, "_way"}, 64'(data_way_o), 64'(0));
    chk({p, "_mem_valid"}, 64'(mem_valid_o), 64'(0));
    chk({p, "_wq_empty"}, 64'(wq_empty_o), 64'(1));
  endtask

  task automatic drain(input string p);
    int n;
    n = 0;
    while (!wq_empty_o && n < 30) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk({p, "_drained"}, 64'(wq_empty_o), 64'(1));
  endtask

  dcache_req_i_t sa, sb, se, sf;
  dcache_req_i_t sg [3];
  dcache_req_i_t sc [6];
  dcache_req_i_t sd [6];
  int k;

  initial begin
    req = '0;
    arb_gnt_i = 1'b1;
    mem_ready_i = 1'b1;
    tag_rdata_i = '0;
    for (int i = 0; i < 6; i++) begin
      sc[i] = mk(12'h100 + 12'(i*8), 44'h100 + 44'(i),
                 64'hC0 + 64'(i), 8'(1 << i), 2'd3);
      sd[i] = mk(12'h200 + 12'(i*8), 44'h200 + 44'(i),
                 64'hD0 + 64'(i), 8'hFF, 2'd1);
    end

    repeat (3) @(negedge clk_i);
    #1;
    reset_chk("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // single store, hit in way 2
    @(negedge clk_i);
    sa = mk(12'h5A8, 44'hABCDEF01234, 64'h1122334455667788,
            8'h0F, 2'd3);
    req = sa;
    exp_q.push_back(ent(sa));
    #1;
    chk("A_gnt", 64'(rsp.data_gnt), 64'(1));
    chk("A_tag_req", 64'(tag_req_o), 64'(1));
    chk("A_tag_addr", 64'(tag_addr_o), 64'h5A);
    @(negedge clk_i);
    tag_rdata_i = tags(2, sa.address_tag);
    #1;
    chk("A_no_gnt_lookup", 64'(rsp.data_gnt), 64'(0));
    chk("A_data_we", 64'(data_we_o), 64'(1));
    chk("A_way", 64'(data_way_o), 64'h4);
    chk("A_data_addr", 64'(data_addr_o), 64'hB5);
    chk("A_wdata", data_wdata_o, 64'h1122334455667788);
    chk("A_be", 64'(data_be_o), 64'h0F);
    chk("A_wq_busy", 64'(wq_empty_o), 64'(0));
    @(negedge clk_i);
    req = '0;
    #1;
    chk("A_mem_valid", 64'(mem_valid_o), 64'(1));
    chk("A_mem_addr", 64'(mem_addr_o), 64'h00ABCDEF012345A8);
    chk("A_mem_data", mem_data_o, 64'h1122334455667788);
    chk("A_mem_be", 64'(mem_be_o), 64'h0F);
    chk("A_mem_size", 64'(mem_size_o), 64'(3));
    chk("A_we_off", 64'(data_we_o), 64'(0));
    @(negedge clk_i);
    #1;
    chk("A_wq_empty", 64'(wq_empty_o), 64'(1));
    chk("A_mem_idle", 64'(mem_valid_o), 64'(0));

    // miss: way 0 has matching tag but is invalid
    @(negedge clk_i);
    sb = mk(12'h010, 44'h00000000777, 64'hCAFEBABE00000001,
            8'hF0, 2'd2);
    req = sb;
    exp_q.push_back(ent(sb));
    #1;
    chk("B_gnt", 64'(rsp.data_gnt), 64'(1));
    @(negedge clk_i);
    req = '0;
    tag_rdata_i = tags(-1, sb.address_tag);
    #1;
    chk("B_data_we", 64'(data_we_o), 64'(0));
    chk("B_way", 64'(data_way_o), 64'(0));
    @(negedge clk_i);
    #1;
    chk("B_mem_valid", 64'(mem_valid_o), 64'(1));
    chk("B_mem_addr", 64'(mem_addr_o), 64'h0000000000777010);
    chk("B_mem_data", mem_data_o, 64'hCAFEBABE00000001);
    chk("B_mem_be", 64'(mem_be_o), 64'hF0);
    chk("B_mem_size", 64'(mem_size_o), 64'(2));
    @(negedge clk_i);
    #1;
    chk("B_mem_idle", 64'(mem_valid_o), 64'(0));

    // six back-to-back stores against a stalled memory
    tag_rdata_i = '0;
    mem_ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      req = sc[k];
      #1;
      chk($sformatf("C_gnt%0d", c), 64'(rsp.data_gnt),
          64'((c < 8) && (c % 2 == 0)));
      if ((c < 8) && (c % 2 == 0)) begin
        exp_q.push_back(ent(sc[k]));
        k++;
      end
    end
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    req = sc[4];
    #1;
    chk("C_gnt_release", 64'(rsp.data_gnt), 64'(1));
    chk("C_head", 64'(mem_addr_o), 64'h00000000100100);
    exp_q.push_back(ent(sc[4]));
    @(negedge clk_i);
    req = sc[5];
    #1;
    chk("C_gnt_lookup", 64'(rsp.data_gnt), 64'(0));
    @(negedge clk_i);
    #1;
    chk("C_gnt_last", 64'(rsp.data_gnt), 64'(1));
    exp_q.push_back(ent(sc[5]));
    @(negedge clk_i);
    req = '0;
    #1;
    drain("C");

    // push+pop at count 3, then a 3-cycle stall on the head
    mem_ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (c == 7) mem_ready_i = 1'b1;
      req = sd[k];
      #1;
      chk($sformatf("D_gnt%0d", c), 64'(rsp.data_gnt),
          64'((c < 7) && (c % 2 == 0)));
      if ((c < 7) && (c % 2 == 0)) begin
        exp_q.push_back(ent(sd[k]));
        k++;
      end
    end
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    req = sd[4];
    #1;
    chk("D_gnt_cnt3", 64'(rsp.data_gnt), 64'(1));
    exp_q.push_back(ent(sd[4]));
    chk("D_hold0_addr", 64'(mem_addr_o), 64'h00000000201208);
    chk("D_hold0_data", mem_data_o, 64'hD1);
    @(negedge clk_i);
    req = sd[5];
    #1;
    chk("D_hold1_addr", 64'(mem_addr_o), 64'h00000000201208);
    chk("D_hold1_data", mem_data_o, 64'hD1);
    @(negedge clk_i);
    #1;
    chk("D_gnt_full", 64'(rsp.data_gnt), 64'(0));
    chk("D_hold2_addr", 64'(mem_addr_o), 64'h00000000201208);
    chk("D_hold2_data", mem_data_o, 64'hD1);
    chk("D_hold2_valid", 64'(mem_valid_o), 64'(1));
    @(negedge clk_i);
    req = '0;
    mem_ready_i = 1'b1;
    #1;
    drain("D");

    // read request is never granted
    @(negedge clk_i);
    sf = mk(12'h040, 44'h5, 64'h5, 8'h01, 2'd0);
    sf.data_we = 1'b0;
    req = sf;
    #1;
    chk("F_read_gnt", 64'(rsp.data_gnt), 64'(0));
    chk("F_read_tag_req", 64'(tag_req_o), 64'(0));

    // arbiter withholds the SRAMs
    se = mk(12'h080, 44'h66, 64'hEE, 8'h3C, 2'd2);
    arb_gnt_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      req = se;
      #1;
      chk($sformatf("E_gnt%0d", c), 64'(rsp.data_gnt), 64'(0));
      chk($sformatf("E_tag_req%0d", c), 64'(tag_req_o), 64'(0));
    end
    @(negedge clk_i);
    arb_gnt_i = 1'b1;
    #1;
    chk("E_gnt_arb", 64'(rsp.data_gnt), 64'(1));
    chk("E_tag_req_arb", 64'(tag_req_o), 64'(1));
    exp_q.push_back(ent(se));
    @(negedge clk_i);
    req = '0;
    #1;
    drain("E");

    // reset while a store is in LOOKUP with two queued
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++)
      sg[i] = mk(12'h300 + 12'(i*8), 44'h300 + 44'(i),
                 64'hF0 + 64'(i), 8'hFF, 2'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      req = sg[c / 2];
      #1;
    end
    chk("G_gnt_last", 64'(rsp.data_gnt), 64'(1));
    @(negedge clk_i);
    req = '0;
    tag_rdata_i = tags(1, sg[2].address_tag);
    mem_ready_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    reset_chk("G_rst0");
    @(negedge clk_i);
    #1;
    reset_chk("G_rst1");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("G_mem_idle", 64'(mem_valid_o), 64'(0));
    chk("G_wq_empty", 64'(wq_empty_o), 64'(1));

    chk("log_size", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("log%0d_addr", i), 64'(got_q[i].addr),
          64'(exp_q[i].addr));
      chk($sformatf("log%0d_data", i), got_q[i].data, exp_q[i].data);
      chk($sformatf("log%0d_be", i), 64'(got_q[i].be),
          64'(exp_q[i].be));
      chk($sformatf("log%0d_size", i), 64'(got_q[i].size),
          64'(exp_q[i].size));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
